// File: rtl/uart_mmio_if.sv
// CPU I/O-bus port of the memory-mapped UART: address, strobes and data.
interface uart_mmio_if;
    logic [31:0] io_addr;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (output io_addr, io_re, io_we, io_wdata, input io_rdata);
    modport slave  (input io_addr, io_re, io_we, io_wdata, output io_rdata);
endinterface

// File: rtl/uart_mmio.sv
// Polled 8N1 UART at 0x8000_0000: status/data registers, TX and RX bit engines.
module uart_mmio #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    uart_mmio_if.slave bus,
    input  logic       serial_in,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] BIT_END  = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] HALF_END = CW'(SYMBOL_EDGE_TIME / 2 - 1);

    localparam logic [31:0] A_TXS = 32'h8000_0000;
    localparam logic [31:0] A_RXS = 32'h8000_0004;
    localparam logic [31:0] A_TXD = 32'h8000_0008;
    localparam logic [31:0] A_RXD = 32'h8000_000C;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_e;

    logic rd_rxs, rd_rxd, wr_txd;
    logic [23:0] unused_wdata;
    assign rd_rxs = bus.io_re && (bus.io_addr == A_RXS);
    assign rd_rxd = bus.io_re && (bus.io_addr == A_RXD);
    assign wr_txd = bus.io_we && (bus.io_addr == A_TXD);
    assign unused_wdata = bus.io_wdata[31:8];

    // ---------------- transmitter ----------------
    uart_st_e      tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_out_q, tx_out_d;
    logic          tx_ready;

    assign tx_ready   = (tx_state_q == IDLE);
    assign serial_out = tx_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_out_q   <= tx_out_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        unique case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                // writes while busy never reach this branch, so they are dropped
                if (wr_txd) begin
                    tx_state_d = START;
                    tx_byte_d  = bus.io_wdata[7:0];
                end
            end
            START: if (tx_cnt_q == BIT_END) begin
                tx_state_d = DATA;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
            end
            DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0;
                tx_idx_d = tx_idx_q + 1'b1;
                if (tx_idx_q == 3'd7) tx_state_d = STOP;
            end
            STOP: if (tx_cnt_q == BIT_END) begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
            end
            default: tx_state_d = IDLE;
        endcase
        // line level is registered from the next state so serial_out is glitch-free
        tx_out_d = 1'b1;
        if (tx_state_d == START) tx_out_d = 1'b0;
        if (tx_state_d == DATA)  tx_out_d = tx_byte_d[tx_idx_d];
    end

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    uart_st_e      rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          byte_done, frame_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= serial_in;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        unique case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rx_state_d = START;
            end
            // half a bit in: a line back high means the start was a glitch
            START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 1'b1;
                if (rx_idx_q == 3'd7) rx_state_d = STOP;
            end
            STOP: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_state_d = IDLE;
                byte_done  = rx_s2_q;
                frame_bad  = !rx_s2_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- register file ----------------
    logic        rx_valid_q, rx_valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [31:0] rdata_q, rdata_d;

    assign bus.io_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rx_byte_q  <= '0;
            rdata_q    <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            rx_byte_q  <= rx_byte_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        rx_valid_d = rx_valid_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        rx_byte_d  = rx_byte_q;
        if (rd_rxd) rx_valid_d = 1'b0;
        if (rd_rxs) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // new events outrank the clearing reads in the same cycle
        if (byte_done) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
            if (rx_valid_q && !rd_rxd) ovr_d = 1'b1;
        end
        if (frame_bad) ferr_d = 1'b1;

        rdata_d = rdata_q;
        if (bus.io_re) begin
            case (bus.io_addr)
                A_TXS:   rdata_d = {31'b0, tx_ready};
                A_RXS:   rdata_d = {29'b0, ovr_q, ferr_q, rx_valid_q};
                A_RXD:   rdata_d = {24'b0, rx_byte_q};
                default: rdata_d = '0;
            endcase
        end
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART responder on the CPU's I/O bus at 0x8000_0000. It answers the status polls, data reads and data writes that polling software issues, and runs the serial 8N1 transmitter and receiver behind those registers. It sits between the datapath's I/O port and the board-level serial pins.

## Interface
Parameters:
- CLOCK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- Derived value SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, integer division (434 at defaults).

Ports (the reset, `rst`, is asynchronous and active-low):
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- io_addr  input  32  byte address of the access.
- io_re  input  1  read strobe, one cycle per access.
- io_we  input  1  write strobe, one cycle per access.
- io_wdata  input  32  write data; only bits [7:0] are used.
- io_rdata  output  32  registered read data.
- serial_in  input  1  asynchronous RX line; idles high.
- serial_out  output  1  TX line; idles high.

## Operation
Register map. Decode is a full 32-bit match; unmapped addresses read 0, and writes to them are ignored.
- 0x8000_0000 TX status, read: bit0 = tx_ready; other bits 0.
- 0x8000_0004 RX status, read:
  - bit0 = rx_valid.
  - bit1 = frame_err (sticky).
  - bit2 = overrun (sticky).
  - Reading this register clears bit1 and bit2 at that edge.
- 0x8000_0008 TX data, write: byte = io_wdata[7:0]. Reads return 0.
- 0x8000_000C RX data, read: {24'b0, rx_byte}. The read clears rx_valid at that edge.

TX FSM (IDLE, START, DATA, STOP):
- In IDLE, a write to 0x8000_0008 with tx_ready=1 latches the byte, drops tx_ready and enters START.
- A write while tx_ready=0 is dropped silently. The byte in flight is unaffected.
- Each state drives its bit for exactly SYMBOL_EDGE_TIME cycles:
  - START drives 0.
  - DATA drives bits 0..7, LSB first, with a 3-bit index.
  - STOP drives 1.
- At the end of STOP the FSM returns to IDLE and tx_ready=1.

RX FSM (IDLE, START, DATA, STOP):
- serial_in passes through a 2-flop synchronizer before any use.
- In IDLE, a synchronized 1→0 transition enters START.
- After SYMBOL_EDGE_TIME/2 cycles the line is sampled:
  - If it is 1, the start was a glitch; return to IDLE with nothing recorded.
  - If it is 0, enter DATA.
- Each data bit is then sampled at SYMBOL_EDGE_TIME intervals (mid-bit), LSB first, 8 bits, then STOP is sampled.
- Stop bit = 1: the byte loads rx_byte and sets rx_valid.
  - If rx_valid was already 1, set overrun; the new byte replaces the old one.
- Stop bit = 0: discard the byte, set frame_err, leave rx_valid and rx_byte unchanged.
- After STOP, return to IDLE. The next falling edge is accepted immediately.

Simultaneous events:
- A byte completes in the same cycle as a read of 0x8000_000C:
  - The read returns the old byte.
  - The new byte loads and rx_valid stays 1.
  - No overrun is flagged.
- A status read coincides with a new frame_err or overrun: the new event wins and the bit stays 1.
- io_re and io_we in the same cycle: both take effect. A write can only hit 0x8000_0008 and a read of that address returns 0, so the two never conflict.

Reset (rst=0, async):
- Both FSMs go to IDLE.
- serial_out=1, tx_ready=1.
- rx_valid, frame_err, overrun = 0.
- rx_byte=0, io_rdata=0.
- Synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame; no partial byte is reported.

## Timing
Bus side:
- io_rdata is registered: a read in cycle N shows its data in cycle N+1 (matches the load delay slot).
- io_rdata holds that value until the next read; cycles without a read do not change it.
- Status side effects (clear rx_valid, clear sticky bits) take effect at the edge ending cycle N. A read in cycle N+1 sees the cleared value.

TX:
- Write in cycle N: tx_ready reads 0 from cycle N+1. serial_out falls at edge N+1.
- The frame lasts 10·SYMBOL_EDGE_TIME cycles.
- tx_ready=1 and IDLE are reached 10·SYMBOL_EDGE_TIME cycles after serial_out falls. A back-to-back write is accepted in that cycle.

RX:
- rx_valid rises within 2 + 9.5·SYMBOL_EDGE_TIME ±1 cycles of the serial_in falling edge.
- Counter widths: a counter sized by $clog2(SYMBOL_EDGE_TIME). The counter resets to 0 at each bit boundary, with no wrap-around error at max count.

## Test plan
- Reset check: assert rst=0 mid-TX frame → serial_out=1 and io_rdata=0. A read of 0x8000_0000 after release returns 0x1.
- TX of 0xA5: write 0x8000_0008 → serial_out reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 434 cycles. tx_ready=0 throughout and 1 after.
- Write 0x3C while busy sending 0x5A → 0x3C never appears on serial_out; 0x5A is unaffected.
- Drive 0x41 on serial_in:
  - A read of 0x8000_0004 returns 0x1.
  - A read of 0x8000_000C returns 0x41.
  - The next status read returns 0x0.
- Send 0x11 then 0x22 with no read in between → status = 0x5, data = 0x22. The second status read returns 0x1 (overrun cleared).
- Frame with stop bit = 0 → status bit1 = 1, rx_valid unchanged. A 100-cycle low glitch on serial_in produces no byte and no error.
